// File: rtl/axi_uart_responder.sv
// axi_uart_responder: AXI4-Lite register front end for a UART core.
// It holds an RX FIFO and a TX FIFO, a status register, a control register
// and a one-cycle interrupt pulse.
//   clk, rstn             clock and synchronous active-low reset
//   uart_axi_ar*/r*       read channel: 0x0 pops RX, 0x8 returns status
//   uart_axi_aw*/w*/b*    write channel: 0x4 pushes TX, 0xC is control
//   tx_data/tx_valid/...  TX FIFO head offered to the serializer
//   rx_data/rx_valid      byte strobe from the deserializer, no backpressure
//   intr                  pulse on RX empty->non-empty or TX non-empty->empty
`timescale 1ns/1ps
module axi_uart_responder #(
   parameter int unsigned DEPTH = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  uart_axi_araddr,
   input  logic        uart_axi_arvalid,
   output logic        uart_axi_arready,
   output logic [31:0] uart_axi_rdata,
   output logic [1:0]  uart_axi_rresp,
   output logic        uart_axi_rvalid,
   input  logic        uart_axi_rready,
   input  logic [3:0]  uart_axi_awaddr,
   input  logic        uart_axi_awvalid,
   output logic        uart_axi_awready,
   input  logic [31:0] uart_axi_wdata,
   input  logic [3:0]  uart_axi_wstrb,
   input  logic        uart_axi_wvalid,
   output logic        uart_axi_wready,
   output logic [1:0]  uart_axi_bresp,
   output logic        uart_axi_bvalid,
   input  logic        uart_axi_bready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        intr
);

   localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   localparam logic [3:0] ADDR_RX   = 4'h0;
   localparam logic [3:0] ADDR_TX   = 4'h4;
   localparam logic [3:0] ADDR_STAT = 4'h8;
   localparam logic [3:0] ADDR_CTRL = 4'hC;

   logic [7:0]    rx_mem_q [DEPTH];
   logic [7:0]    tx_mem_q [DEPTH];
   logic [AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
   logic [AW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic          overrun_q, overrun_d, ien_q, ien_d;
   logic          arready_q, arready_d, rvalid_q, rvalid_d, bvalid_q, bvalid_d;
   logic          intr_q, intr_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          rx_empty, rx_full, tx_empty, tx_full;
   logic          ar_acc, wr_go, ctrl_wr, stat_rd;
   logic          rx_push, rx_pop, rx_flush, tx_push, tx_pop, tx_flush;
   logic          ovr_set;
   logic [7:0]    rx_head;
   logic [31:0]   stat_val, rd_val;
   logic          unused_ok;

   assign unused_ok = ^{uart_axi_wstrb, uart_axi_wdata[31:8]};

   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CW'(DEPTH));
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == CW'(DEPTH));
   assign rx_head  = rx_mem_q[rx_rd_q];

   // Handshake qualifiers; the write ready is combinational so the write lands in the valid cycle
   assign ar_acc   = arready_q & uart_axi_arvalid;
   assign wr_go    = rstn & uart_axi_awvalid & uart_axi_wvalid & ~bvalid_q;
   assign ctrl_wr  = wr_go & (uart_axi_awaddr == ADDR_CTRL);
   assign stat_rd  = ar_acc & (uart_axi_araddr == ADDR_STAT);
   assign rx_flush = ctrl_wr & uart_axi_wdata[1];
   assign tx_flush = ctrl_wr & uart_axi_wdata[0];
   assign rx_pop   = ar_acc & (uart_axi_araddr == ADDR_RX) & ~rx_empty;
   assign rx_push  = rx_valid & (~rx_full | rx_pop);
   assign ovr_set  = rx_valid & rx_full & ~rx_pop;
   assign tx_pop   = ~tx_empty & tx_ready;
   assign tx_push  = wr_go & (uart_axi_awaddr == ADDR_TX) & ~tx_full;

   assign stat_val = {26'b0, overrun_q, ien_q, tx_full, tx_empty, rx_full, ~rx_empty};

   // Read data mux, sampled in the acceptance cycle
   always_comb begin
      rd_val = '0;
      case (uart_axi_araddr)
         ADDR_RX:   rd_val = rx_empty ? 32'h0 : {24'b0, rx_head};
         ADDR_STAT: rd_val = stat_val;
         default:   rd_val = '0;
      endcase
   end

   // Next-state for channels, control and both FIFOs; flush overrides push/pop
   always_comb begin
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      bvalid_d  = bvalid_q;
      ien_d     = ien_q;
      overrun_d = overrun_q;
      rx_rd_d   = rx_rd_q;
      rx_wr_d   = rx_wr_q;
      rx_cnt_d  = rx_cnt_q;
      tx_rd_d   = tx_rd_q;
      tx_wr_d   = tx_wr_q;
      tx_cnt_d  = tx_cnt_q;
      intr_d    = 1'b0;

      if (ar_acc) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
      end else if (rvalid_q && uart_axi_rready) begin
         rvalid_d = 1'b0;
      end
      arready_d = ~rvalid_d;

      if (wr_go) begin
         bvalid_d = 1'b1;
      end else if (bvalid_q && uart_axi_bready) begin
         bvalid_d = 1'b0;
      end

      if (ctrl_wr) ien_d = uart_axi_wdata[4];

      // A fresh overrun in the clearing cycle wins so the event is not lost
      overrun_d = ovr_set | (overrun_q & ~stat_rd);

      if (rx_flush) begin
         rx_rd_d  = '0;
         rx_wr_d  = '0;
         rx_cnt_d = '0;
      end else begin
         if (rx_push) rx_wr_d = rx_wr_q + AW'(1);
         if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
         endcase
      end

      if (tx_flush) begin
         tx_rd_d  = '0;
         tx_wr_d  = '0;
         tx_cnt_d = '0;
      end else begin
         if (tx_push) tx_wr_d = tx_wr_q + AW'(1);
         if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
         endcase
      end

      intr_d = ien_q & (((rx_cnt_q == '0) && (rx_cnt_d != '0)) ||
                        ((tx_cnt_q != '0) && (tx_cnt_d == '0)));
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         bvalid_q  <= 1'b0;
         ien_q     <= 1'b0;
         overrun_q <= 1'b0;
         intr_q    <= 1'b0;
         rx_rd_q   <= '0;
         rx_wr_q   <= '0;
         rx_cnt_q  <= '0;
         tx_rd_q   <= '0;
         tx_wr_q   <= '0;
         tx_cnt_q  <= '0;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         bvalid_q  <= bvalid_d;
         ien_q     <= ien_d;
         overrun_q <= overrun_d;
         intr_q    <= intr_d;
         rx_rd_q   <= rx_rd_d;
         rx_wr_q   <= rx_wr_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_rd_q   <= tx_rd_d;
         tx_wr_q   <= tx_wr_d;
         tx_cnt_q  <= tx_cnt_d;
      end
   end

   // FIFO storage; contents need no reset since counts gate every read
   always_ff @(posedge clk) begin
      if (rx_push && !rx_flush) rx_mem_q[rx_wr_q] <= rx_data;
      if (tx_push && !tx_flush) tx_mem_q[tx_wr_q] <= uart_axi_wdata[7:0];
   end

   assign uart_axi_arready = arready_q;
   assign uart_axi_rvalid  = rvalid_q;
   assign uart_axi_rdata   = rdata_q;
   assign uart_axi_rresp   = 2'b00;
   assign uart_axi_awready = wr_go;
   assign uart_axi_wready  = wr_go;
   assign uart_axi_bvalid  = bvalid_q;
   assign uart_axi_bresp   = 2'b00;
   assign tx_data          = tx_mem_q[tx_rd_q];
   assign tx_valid         = ~tx_empty;
   assign intr             = intr_q;

endmodule
